// File: rtl/countdown_display_driver.sv
// -----------------------------------------------------------------------------
// countdown_display_driver
//
// Purpose:
//   Receives the NS and EW countdown values from the traffic-light controller.
//   Each value is converted to two BCD digits by a sequential double-dabble
//   engine that handles both directions in parallel. The result drives a
//   4-digit, time-multiplexed, active-low 7-segment display. NS uses the two
//   left digits and EW uses the two right digits.
//
// Parameters:
//   SCAN_DIV      clk cycles per digit slot (>= 2)
//   BLINK_THRESH  committed values 1..BLINK_THRESH blink (blink build only)
//   BLINK_HALF    scan ticks per blink half-period (blink build only)
//
// Configuration macro:
//   COUNTDOWN_BLINK_EN  when defined, adds the low-count blink logic and the
//                       BLINK_THRESH / BLINK_HALF parameters. When undefined,
//                       the digits are steady.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   ce          in   conversion enable (scanning runs regardless)
//   timeLeftNS  in   [6:0] NS remaining seconds
//   timeLeftEW  in   [6:0] EW remaining seconds
//   seg         out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an          out  [3:0] digit enables, active-low, an[3]=NS tens .. an[0]=EW ones
//   busy        out  high while a conversion is in progress
//   conv_done   out  one-cycle pulse after new values reach the display registers
//
// FSM states:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | waiting for ce and a changed (or never-shown) input pair
//   S_SHIFT  | seven double-dabble steps on both shift registers
//   S_COMMIT | copy BCD into display registers, pulse conv_done
// -----------------------------------------------------------------------------
module countdown_display_driver #(
    parameter int SCAN_DIV     = 1000
`ifdef COUNTDOWN_BLINK_EN
    ,
    parameter int BLINK_THRESH = 3,
    parameter int BLINK_HALF   = 256
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [6:0] timeLeftNS,
    input  logic [6:0] timeLeftEW,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy,
    output logic       conv_done
);

    localparam int PRESC_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_trigger;
    logic         w_load;
    logic         w_step;
    logic         w_commit;

    logic [6:0]   r_snap_ns;
    logic [6:0]   r_snap_ew;
    // Shift registers are {tens[3:0], ones[3:0], binary[6:0]}.
    logic [14:0]  r_dd_ns;
    logic [14:0]  r_dd_ew;
    logic [2:0]   r_bitcnt;
    logic [7:0]   r_disp_ns;
    logic [7:0]   r_disp_ew;
    logic         r_disp_valid;
    logic         r_busy;
    logic         r_conv_done;

    logic [PRESC_W-1:0] r_presc;
    logic         w_tick;
    logic [1:0]   r_slot;
    logic [1:0]   w_slot_nxt;
    logic [6:0]   r_seg;
    logic [3:0]   r_an;
    logic [3:0]   w_digit;
    logic         w_is_tens;
    logic         w_dir_blank;
    logic         w_show;
    logic [6:0]   w_seg_nxt;
    logic [3:0]   w_an_nxt;
    logic         w_blink_ns;
    logic         w_blink_ew;

    // Inputs above 99 are clamped to 99 because two digits cannot show more.
    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    // One double-dabble step: add 3 to each BCD nibble that is >= 5, then
    // shift left. The tens nibble never overflows for inputs <= 99.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = v[14:11];
        o = v[10:7];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t[2:0], o, v[6:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // The snapshot holds the raw values. A saturated input that changes
    // (for example 120 -> 121) therefore still triggers a conversion.
    assign w_trigger = ce && (!r_disp_valid ||
                              ({timeLeftNS, timeLeftEW} != {r_snap_ns, r_snap_ew}));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end
            end
            S_SHIFT: begin
                w_step = 1'b1;
                if (r_bitcnt == 3'd0) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------- conversion path
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_ns    <= 7'd0;
            r_snap_ew    <= 7'd0;
            r_dd_ns      <= 15'd0;
            r_dd_ew      <= 15'd0;
            r_bitcnt     <= 3'd0;
            r_disp_ns    <= 8'd0;
            r_disp_ew    <= 8'd0;
            r_disp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_conv_done  <= 1'b0;
        end else begin
            if (w_load) begin
                r_snap_ns <= timeLeftNS;
                r_snap_ew <= timeLeftEW;
                r_dd_ns   <= {8'd0, sat99(timeLeftNS)};
                r_dd_ew   <= {8'd0, sat99(timeLeftEW)};
                r_bitcnt  <= 3'd6;
            end
            if (w_step) begin
                r_dd_ns  <= dd_step(r_dd_ns);
                r_dd_ew  <= dd_step(r_dd_ew);
                r_bitcnt <= r_bitcnt - 3'd1;
            end
            if (w_commit) begin
                r_disp_ns    <= r_dd_ns[14:7];
                r_disp_ew    <= r_dd_ew[14:7];
                r_disp_valid <= 1'b1;
            end
            // busy is held through the cycle after COMMIT, which is the same
            // cycle in which conv_done is high.
            r_busy      <= (w_state_nxt != S_IDLE) || (r_state == S_COMMIT);
            r_conv_done <= (r_state == S_COMMIT);
        end
    end

    // ---------------------------------------------------------- scan timing
    assign w_tick     = (r_presc == PRESC_W'(SCAN_DIV - 1));
    assign w_slot_nxt = r_slot + 2'd1;

`ifdef COUNTDOWN_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic               w_blink_wrap;
    logic               w_phase_nxt;

    function automatic logic in_blink_range(input logic [7:0] bcd);
        int v;
        v = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
        return (v >= 1) && (v <= BLINK_THRESH);
    endfunction

    assign w_blink_wrap = w_tick && (r_blink_cnt == BLINK_W'(BLINK_HALF - 1));
    // The phase is registered on the same edge as the digit it affects, so
    // the blanking decision uses the phase value that is about to take effect.
    assign w_phase_nxt  = w_blink_wrap ? ~r_blink_phase : r_blink_phase;
    assign w_blink_ns   = w_phase_nxt && in_blink_range(r_disp_ns);
    assign w_blink_ew   = w_phase_nxt && in_blink_range(r_disp_ew);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_tick) begin
            r_blink_cnt   <= w_blink_wrap ? '0 : r_blink_cnt + BLINK_W'(1);
            r_blink_phase <= w_phase_nxt;
        end
    end
`else
    assign w_blink_ns = 1'b0;
    assign w_blink_ew = 1'b0;
`endif

    // Select the digit for the slot that becomes active on this tick.
    always_comb begin
        w_digit     = 4'd0;
        w_is_tens   = 1'b0;
        w_dir_blank = 1'b0;
        w_show      = 1'b0;
        w_seg_nxt   = 7'h7F;
        w_an_nxt    = 4'hF;
        case (w_slot_nxt)
            2'd0: w_digit = r_disp_ew[3:0];
            2'd1: begin
                w_digit   = r_disp_ew[7:4];
                w_is_tens = 1'b1;
            end
            2'd2: w_digit = r_disp_ns[3:0];
            default: begin
                w_digit   = r_disp_ns[7:4];
                w_is_tens = 1'b1;
            end
        endcase
        w_dir_blank = w_slot_nxt[1] ? w_blink_ns : w_blink_ew;
        // Tens digits are blanked when zero. Ones digits are always shown.
        w_show = r_disp_valid && !(w_is_tens && (w_digit == 4'd0)) && !w_dir_blank;
        if (w_show) begin
            w_seg_nxt = seg_lut(w_digit);
            w_an_nxt  = ~(4'b0001 << w_slot_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_slot  <= 2'd0;
            r_seg   <= 7'h7F;
            r_an    <= 4'hF;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
                r_slot <= w_slot_nxt;
                r_seg  <= w_seg_nxt;
                r_an   <= w_an_nxt;
            end
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign busy      = r_busy;
    assign conv_done = r_conv_done;

endmodule

// File: tb/tb_countdown_display_driver.sv
module tb_countdown_display_driver;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_THRESH = 3;
    localparam int BLINK_HALF   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic [6:0] timeLeftNS = 7'd0;
    logic [6:0] timeLeftEW = 7'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic       conv_done;

    countdown_display_driver #(
        .SCAN_DIV(SCAN_DIV)
`ifdef COUNTDOWN_BLINK_EN
        ,
        .BLINK_THRESH(BLINK_THRESH),
        .BLINK_HALF(BLINK_HALF)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .timeLeftNS(timeLeftNS),
        .timeLeftEW(timeLeftEW),
        .seg(seg),
        .an(an),
        .busy(busy),
        .conv_done(conv_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Number of non-reset rising edges since the last reset edge.
    int e_cnt = 0;
    always @(posedge clk) begin
        if (rst) e_cnt <= 0;
        else     e_cnt <= e_cnt + 1;
    end

    // Reference state: the raw values that should be on the display.
    int model_ns    = 0;
    int model_ew    = 0;
    bit model_valid = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    // Lit segments (active-high, bit0=a .. bit6=g) for each decimal digit.
    function automatic int seg_of(input int d);
        int lit;
        case (d)
            0: lit = 'h3F;  1: lit = 'h06;  2: lit = 'h5B;  3: lit = 'h4F;
            4: lit = 'h66;  5: lit = 'h6D;  6: lit = 'h7D;  7: lit = 'h07;
            8: lit = 'h7F;  default: lit = 'h6F;
        endcase
        return (~lit) & 'h7F;
    endfunction

    // Expected display from the elapsed scan ticks and the committed values.
    task automatic check_display(input string tag);
        int w, slot, val, digit, exp_an, exp_seg;
        bit blank;
        w = e_cnt / SCAN_DIV;
        exp_an = 'hF;
        exp_seg = 'h7F;
        if (w > 0) begin
            slot  = w % 4;
            val   = (slot >= 2) ? sat(model_ns) : sat(model_ew);
            digit = (slot % 2 == 1) ? val / 10 : val % 10;
            blank = !model_valid || ((slot % 2 == 1) && (digit == 0));
`ifdef COUNTDOWN_BLINK_EN
            if (((w / BLINK_HALF) % 2 == 1) && val >= 1 && val <= BLINK_THRESH)
                blank = 1'b1;
`endif
            if (!blank) begin
                exp_an  = 'hF & ~(1 << slot);
                exp_seg = seg_of(digit);
            end
        end
        check_val({tag, "_an"}, int'(an), exp_an);
        check_val({tag, "_seg"}, int'(seg), exp_seg);
    endtask

    // Let every slot refresh from the committed values, then check two full scans.
    task automatic settle_and_scan(input string tag);
        repeat (SCAN_DIV * 4 + 2) @(negedge clk);
        check_val({tag, "_idle_busy"}, int'(busy), 0);
        for (int i = 0; i < SCAN_DIV * 8; i++) begin
            @(negedge clk);
            check_display(tag);
        end
    endtask

    // Called at a negedge with the DUT idle. Waits a bounded number of edges
    // for conv_done and checks that it arrives on the ninth edge (T0..T8).
    // ce is dropped at a random point to show that it cannot abort a conversion.
    task automatic convert(input int ns, input int ew, input string tag);
        int n;
        int drop_at;
        bit seen;
        check_val({tag, "_pre_busy"}, int'(busy), 0);
        timeLeftNS = 7'(ns);
        timeLeftEW = 7'(ew);
        ce = 1'b1;
        drop_at = $urandom_range(1, 12);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) check_val({tag, "_busy_t0"}, int'(busy), 1);
            if (n == drop_at) ce = 1'b0;
            if (conv_done) seen = 1'b1;
        end
        check_val({tag, "_latency"}, n, 9);
        check_val({tag, "_busy_done"}, int'(busy), 1);
        @(negedge clk);
        check_val({tag, "_pulse"}, int'(conv_done), 0);
        ce = 1'b1;
        model_ns = ns;
        model_ew = ew;
        model_valid = 1'b1;
    endtask

    initial begin
        int ns, ew, n, first, second;

        // Reset with ce low; display must remain blank while ce stays low.
        rst = 1'b1;
        ce  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_seg", int'(seg), 'h7F);
        check_val("rst_an", int'(an), 'hF);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(conv_done), 0);
        rst = 1'b0;
        timeLeftNS = 7'd55;
        timeLeftEW = 7'd13;
        repeat (30) @(negedge clk);
        check_val("ce0_busy", int'(busy), 0);
        check_display("ce0_disp");

        // Directed values, including saturation, zero, and the blink candidate.
        convert(42, 7, "d42_7");
        settle_and_scan("d42_7");
        convert(120, 0, "d120_0");
        settle_and_scan("d120_0");
        convert(0, 99, "d0_99");
        settle_and_scan("d0_99");
        convert(2, 30, "d2_30");
        settle_and_scan("d2_30");

        // Random pairs; a pair is always distinct from the previous one.
        for (int k = 0; k < 8; k++) begin
            ns = int'($urandom_range(0, 127));
            ew = int'($urandom_range(0, 127));
            if (ns == model_ns && ew == model_ew) ew = (ew + 1) % 128;
            convert(ns, ew, "rand");
            settle_and_scan("rand");
        end

        // Input changes mid-conversion: expect two back-to-back conversions.
        timeLeftNS = 7'd10;
        timeLeftEW = 7'd5;
        ce = 1'b1;
        n = 0;
        first = 0;
        second = 0;
        while (second == 0 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 4) timeLeftNS = 7'd11;
            if (conv_done) begin
                if (first == 0) first = n;
                else second = n;
            end
        end
        check_val("b2b_first", first, 9);
        check_val("b2b_second", second, 18);
        model_ns = 11;
        model_ew = 5;
        model_valid = 1'b1;
        settle_and_scan("b2b");

        // Reset arriving at T4 of a conversion.
        timeLeftNS = 7'd63;
        timeLeftEW = 7'd8;
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_seg", int'(seg), 'h7F);
        check_val("midrst_an", int'(an), 'hF);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_done", int'(conv_done), 0);
        model_valid = 1'b0;
        rst = 1'b0;
        n = 0;
        first = 0;
        while (first == 0 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (conv_done) first = n;
        end
        check_val("midrst_latency", first, 9);
        model_ns = 63;
        model_ew = 8;
        model_valid = 1'b1;
        settle_and_scan("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
